bsg_clk_gen_switch_ctrl: RTL
============================

# bsg_clk_gen_switch_ctrl

Multi-channel, glitch-safe clock-select sequencer for a cluster of `num_clks_p` clock generators. It accepts one reconfiguration request at a time over a valid/ready handshake. For each request it gates the target channel's output, optionally pulses that channel's oscillator reset, applies the new select, and waits a settle interval before signalling completion. It sits beside the per-channel clock-generator pearls and drives their `select_i` and `async_osc_reset_i` inputs, replacing per-channel tag-driven select and reset clients.

## Interface
- `num_clks_p`, 4: number of clock-generator channels, ≥1.
- `gate_cycles_p`, 16: cycles the target channel is held at select 2'b11 (off) before any other action, ≥1.
- `osc_reset_cycles_p`, 8: cycles of oscillator-reset assertion, ≥1.
- `settle_cycles_p`, 64: cycles after the new select is applied before completion, ≥1.
- `reset_sel_p`, 2'b10: select value for every channel after reset (external clock).
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `v_i`  in  1  request valid.
- `ready_and_o`  out  1  request accepted when `v_i & ready_and_o`.
- `clk_id_i`  in  `BSG_SAFE_CLOG2(num_clks_p)`  target channel.
- `sel_i`  in  2  new select: 00 osc, 01 downsampled osc, 10 ext, 11 off.
- `osc_reset_i`  in  1  pulse the oscillator reset during this request.
- `global_disable_i`  in  1  force every `sel_o` entry to 2'b11 combinationally.
- `sel_o`  out  `num_clks_p`×2  per-channel select.
- `osc_reset_o`  out  `num_clks_p`  per-channel oscillator reset.
- `busy_o`  out  1  sequence in progress; equals `~ready_and_o`.
- `done_v_o`  out  1  one-cycle pulse when a request completes.

## Operation
- Reset values:
  - `sel_o` is `reset_sel_p` on all channels.
  - `osc_reset_o` is all-1 with the macro enabled, all-0 without it.
  - `ready_and_o` = 1, `busy_o` = 0, `done_v_o` = 0.
- States: IDLE, GATE, ORST, SETTLE, DONE.
- IDLE:
  - `ready_and_o` = 1.
  - On accept, latch id, sel and osc_reset, then go to GATE.
  - Exception: if the latched sel equals the current `sel_o[id]` and osc_reset = 0, go straight to DONE.
- GATE: the channel's registered select is 2'b11. Count to `gate_cycles_p`-1, then go to ORST if the latched osc_reset = 1, else go to SETTLE.
- ORST: `osc_reset_o[id]` = 1. Count to `osc_reset_cycles_p`-1. On exit, clear `osc_reset_o[id]` and go to SETTLE.
- SETTLE: the channel's registered select is the latched sel. Count `settle_cycles_p` cycles, then go to DONE.
- DONE: `done_v_o` = 1 for one cycle, then return to IDLE.
- Non-target channels never change.
- A cleared `osc_reset_o` bit stays 0 until a later ORST on that channel.
- Out-of-range `clk_id_i` (≥ `num_clks_p`): accepted as a no-op and goes directly to DONE.
- `global_disable_i` masks outputs only. It does not stall the FSM or alter any stored state; on deassertion the stored selects reappear.
- `reset_i` mid-sequence: all state returns to reset values at the next edge, no `done_v_o` is produced, and the pending request is discarded.

## Timing
- Accept at edge 0 (full sequence, macro enabled):
  - GATE covers cycles 1..G.
  - ORST covers the next R cycles.
  - SETTLE covers the next S cycles.
  - `done_v_o` is high in cycle 1+G+R+S.
  - `ready_and_o` returns to 1 in cycle 2+G+R+S.
- Without ORST, drop R from the above.
- No-op request: `done_v_o` in cycle 1, ready again in cycle 2.
- `sel_o` and `osc_reset_o` are registered, with no combinational path from the request inputs. The only combinational path is `global_disable_i` → `sel_o`.
- The `sel_o` transition order for the target channel is always old → 11 → new. There is never a direct old → new change.

## Configuration
- `BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN` defined:
  - ORST state present.
  - `osc_reset_o` resets to all-1; each oscillator stays held until its first request with `osc_reset_i` = 1.
- Undefined:
  - ORST, its counter and the `osc_reset_o` registers are removed.
  - `osc_reset_o` is tied to 0 and `osc_reset_i` is ignored.

## Structure
- `bsg_clk_gen_pkg` gains:
  - a select enum (OSC, DS, EXT, OFF = 2'b11);
  - the FSM state enum.
- One sub-module: `bsg_clk_gen_switch_timer`, a loadable down-counter shared by GATE/ORST/SETTLE.
  - Width is `BSG_SAFE_CLOG2` of the maximum cycle parameter plus 1.
  - Ports: load, load value, `zero_o`.

## Test plan
- Reset, then request id 2, sel 00, osc_reset 1 (G=16, R=8, S=64):
  - `sel_o[2]` is 11 in cycles 1–24.
  - `osc_reset_o[2]` is high in cycles 17–24, then low.
  - `sel_o[2]` = 00 from cycle 25.
  - `done_v_o` in cycle 89.
  - Other channels stay at 10 throughout.
- Request id 1 with sel 10 (equal to current) and osc_reset 0: `done_v_o` in cycle 1, with no change on `sel_o`.
- Hold `v_i` high during a sequence: the second request is not accepted until `ready_and_o` rises. Verify back-to-back completions with no overlap.
- Pulse `global_disable_i` mid-SETTLE:
  - All `sel_o` read 11 while it is high.
  - `done_v_o` timing is unchanged.
  - Stored selects return on release.
- Assert `reset_i` in cycle 10 of GATE: next cycle all outputs are at reset values and no `done_v_o` occurs.
- `num_clks_p` = 3, `clk_id_i` = 3: no-op DONE in cycle 1. Repeat the first scenario with the macro undefined: `osc_reset_o` stays 0 and `done_v_o` occurs in cycle 81.

Source files
------------

// File: rtl/bsg_clk_gen_pkg.sv
// Shared types and helpers for the clock-generator cluster: select encodings,
// switch-controller FSM states and a safe ceil-log2.
package bsg_clk_gen_pkg;

   typedef enum logic [1:0] {
      OSC = 2'b00,
      DS  = 2'b01,
      EXT = 2'b10,
      OFF = 2'b11
   } clk_sel_e;

   typedef enum logic [2:0] {
      IDLE,
      GATE,
      ORST,
      SETTLE,
      DONE
   } switch_state_e;

   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bsg_clk_gen_switch_timer.sv
// Loadable down-counter shared by the GATE/ORST/SETTLE intervals; holds at zero.
module bsg_clk_gen_switch_timer #(
   parameter int unsigned width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic               zero_o
);

   logic [width_p-1:0] cnt_r;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         cnt_r <= '0;
      else if (load_i)
         cnt_r <= load_val_i;
      else if (cnt_r != '0)
         cnt_r <= cnt_r - width_p'(1);
   end

   assign zero_o = (cnt_r == '0);

endmodule

// File: rtl/bsg_clk_gen_switch_ctrl.sv
// Glitch-safe per-channel clock-select sequencer (gate -> optional osc reset -> settle).
// Oscillator-reset support is built only when BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN is defined.
module bsg_clk_gen_switch_ctrl
   import bsg_clk_gen_pkg::*;
#(
   parameter int unsigned num_clks_p         = 4,
   parameter int unsigned gate_cycles_p      = 16,
   parameter int unsigned osc_reset_cycles_p = 8,
   parameter int unsigned settle_cycles_p    = 64,
   parameter logic [1:0]  reset_sel_p        = 2'b10
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 v_i,
   output logic                                 ready_and_o,
   input  logic [safe_clog2(num_clks_p)-1:0]    clk_id_i,
   input  logic [1:0]                           sel_i,
   input  logic                                 osc_reset_i,
   input  logic                                 global_disable_i,
   output logic [num_clks_p-1:0][1:0]           sel_o,
   output logic [num_clks_p-1:0]                osc_reset_o,
   output logic                                 busy_o,
   output logic                                 done_v_o
);

   localparam int unsigned id_width_lp = safe_clog2(num_clks_p);
   localparam int unsigned max_cyc_lp  = max3(gate_cycles_p, osc_reset_cycles_p, settle_cycles_p);
   localparam int unsigned tw_lp       = safe_clog2(max_cyc_lp) + 1;

   localparam logic [tw_lp-1:0] gate_ld_lp   = tw_lp'(gate_cycles_p - 1);
   localparam logic [tw_lp-1:0] settle_ld_lp = tw_lp'(settle_cycles_p - 1);

   switch_state_e state_r, state_n;

   logic [id_width_lp-1:0]    id_r;
   logic [1:0]                sel_new_r;
   logic [num_clks_p-1:0][1:0] sel_r;

   logic             in_range, noop, req_orst;
   logic [1:0]       cur_sel;
   logic             accept, gate_off, apply_sel, orst_set, orst_clr;
   logic             tmr_load, tmr_zero;
   logic [tw_lp-1:0] tmr_val;
   logic             latched_orst;

`ifdef BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN
   localparam logic [tw_lp-1:0] orst_ld_lp = tw_lp'(osc_reset_cycles_p - 1);
   logic                  orst_r;
   logic [num_clks_p-1:0] osc_reset_r;

   assign req_orst     = osc_reset_i;
   assign latched_orst = orst_r;
`else
   logic unused_osc_reset;

   assign unused_osc_reset = osc_reset_i;
   assign req_orst         = 1'b0;
   assign latched_orst     = 1'b0;
`endif

   assign in_range = (32'(clk_id_i) < num_clks_p);

   always_comb begin
      cur_sel = reset_sel_p;
      for (int unsigned i = 0; i < num_clks_p; i++)
         if (32'(clk_id_i) == i) cur_sel = sel_r[i];
   end

   // Requests that would not change the channel skip the gate sequence entirely.
   assign noop = !in_range || ((sel_i == cur_sel) && !req_orst);

   bsg_clk_gen_switch_timer #(
      .width_p(tw_lp)
   ) timer (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .zero_o    (tmr_zero)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i)
         state_r <= IDLE;
      else
         state_r <= state_n;
   end

   always_comb begin
      state_n     = state_r;
      ready_and_o = 1'b0;
      done_v_o    = 1'b0;
      accept      = 1'b0;
      gate_off    = 1'b0;
      apply_sel   = 1'b0;
      orst_set    = 1'b0;
      orst_clr    = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      case (state_r)
         IDLE: begin
            ready_and_o = 1'b1;
            if (v_i) begin
               accept = 1'b1;
               if (noop) begin
                  state_n = DONE;
               end else begin
                  state_n  = GATE;
                  gate_off = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = gate_ld_lp;
               end
            end
         end
         GATE: begin
            if (tmr_zero) begin
`ifdef BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN
               if (latched_orst) begin
                  state_n  = ORST;
                  orst_set = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = orst_ld_lp;
               end else
`endif
               begin
                  state_n   = SETTLE;
                  apply_sel = 1'b1;
                  tmr_load  = 1'b1;
                  tmr_val   = settle_ld_lp;
               end
            end
         end
`ifdef BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN
         ORST: begin
            if (tmr_zero) begin
               state_n   = SETTLE;
               orst_clr  = 1'b1;
               apply_sel = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = settle_ld_lp;
            end
         end
`endif
         SETTLE: begin
            if (tmr_zero) state_n = DONE;
         end
         DONE: begin
            done_v_o = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         id_r      <= '0;
         sel_new_r <= '0;
         sel_r     <= {num_clks_p{reset_sel_p}};
      end else begin
         if (accept) begin
            id_r      <= clk_id_i;
            sel_new_r <= sel_i;
         end
         for (int unsigned i = 0; i < num_clks_p; i++) begin
            if (gate_off && (32'(clk_id_i) == i)) sel_r[i] <= OFF;
            if (apply_sel && (32'(id_r) == i))    sel_r[i] <= sel_new_r;
         end
      end
   end

`ifdef BSG_CLK_GEN_SWITCH_CTRL_OSC_RESET_EN
   // Oscillators are held in reset from power-up until their first reset request.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         orst_r      <= 1'b0;
         osc_reset_r <= '1;
      end else begin
         if (accept) orst_r <= req_orst;
         for (int unsigned i = 0; i < num_clks_p; i++) begin
            if (orst_set && (32'(id_r) == i)) osc_reset_r[i] <= 1'b1;
            if (orst_clr && (32'(id_r) == i)) osc_reset_r[i] <= 1'b0;
         end
      end
   end

   assign osc_reset_o = osc_reset_r;
`else
   assign osc_reset_o = '0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < num_clks_p; i++)
         sel_o[i] = global_disable_i ? OFF : sel_r[i];
   end

   assign busy_o = ~ready_and_o;

endmodule
